// File: rtl/x86_alu_seq.sv
// x86_alu_seq: single-clock multi-phase ALU. An internal phase counter takes
// the place of the old phase clocks. Each accepted instruction emits 1-3
// registered results on alu_result_bus, one per cycle, each tagged with
// result_valid, phase and last.
//
// Handshake: start is sampled on a rising edge and accepted only while
// busy=0. An accepted start raises busy at that edge. busy drops at the edge
// that registers the final phase (the result carrying last), so start may be
// presented again during that last cycle. Unsupported opcodes never raise
// busy; instead illegal pulses for one cycle, one edge after the start.
module x86_alu_seq #(
  parameter int DATA_W      = 32,
  parameter int STEP        = 1,
  parameter bit STACK_DOWN  = 1'b0,
  parameter int SCALE_SHIFT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       ope,
  input  logic [3:0]        num_of_ope,
  input  logic [DATA_W-1:0] registor_in,
  output logic              busy,
  output logic [1:0]        phase,
  output logic              result_valid,
  output logic              last,
  output logic              illegal,
  output logic [DATA_W-1:0] alu_result_bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Signed stack slot step: a downward-growing stack inverts every adjustment.
  localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STEP);
  localparam logic [DATA_W-1:0] S_W    = STACK_DOWN ? -STEP_W : STEP_W;

  logic [0:0]        state;
  logic [1:0]        cnt;
  logic [1:0]        n_q;
  logic [1:0]        start_n;
  logic [31:0]       op_q;
  logic [3:0]        len_q;
  logic              ill_pend;
  logic              is_last;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] d_w;
  logic [DATA_W-1:0] imm24_w;
  logic [DATA_W-1:0] imm8_w;
  logic [DATA_W-1:0] disp8_w;
  logic [DATA_W-1:0] len_w;
  logic [DATA_W-1:0] rel_w;
  logic signed [23:0] rel_s;

  // Number of phases for an instruction word; 0 flags an unsupported one.
  function automatic logic [1:0] phase_count(input logic [31:0] o);
    case (o[31:24])
      8'h55, 8'h53, 8'h5d, 8'hc3, 8'h6a, 8'h8b: phase_count = 2'd2;
      8'h89, 8'hb8:                             phase_count = 2'd1;
      8'he8, 8'hc9:                             phase_count = 2'd3;
      8'h83: begin
        case (o[23:16])
          8'he8, 8'hc4, 8'hec: phase_count = 2'd1;
          default:             phase_count = 2'd0;
        endcase
      end
      default: phase_count = 2'd0;
    endcase
  endfunction

  assign start_n = phase_count(ope);
  assign busy    = state;
  assign is_last = (cnt == n_q - 2'd1);

  // Operand fields taken from the latched instruction word.
  assign d_w     = DATA_W'(op_q[15:8] >> SCALE_SHIFT);
  assign imm24_w = DATA_W'({op_q[7:0], op_q[15:8], op_q[23:16]});
  assign imm8_w  = DATA_W'(op_q[23:16]);
  assign disp8_w = DATA_W'(op_q[15:8]);
  assign len_w   = DATA_W'(len_q);
  assign rel_s   = {op_q[7:0], op_q[15:8], op_q[23:16]};
  assign rel_w   = DATA_W'(rel_s);

  // Result of the current phase for the latched opcode.
  always_comb begin
    res = registor_in;
    case (op_q[31:24])
      8'h55, 8'h53: res = (cnt == 2'd0) ? registor_in + S_W : registor_in;
      8'h89:        res = registor_in;
      8'hb8:        res = imm24_w;
      8'h5d:        res = (cnt == 2'd0) ? registor_in : registor_in - S_W;
      8'hc3:        res = registor_in - S_W;
      8'he8: begin
        case (cnt)
          2'd0:    res = registor_in + S_W;
          2'd1:    res = registor_in + len_w;
          default: res = registor_in + len_w + rel_w - DATA_W'(5);
        endcase
      end
      8'h6a: res = (cnt == 2'd0) ? registor_in + S_W : imm8_w;
      8'h8b: begin
        if (cnt == 2'd0) res = STACK_DOWN ? registor_in + d_w : registor_in - d_w;
        else             res = registor_in;
      end
      8'h83: begin
        case (op_q[23:16])
          8'he8:   res = registor_in - disp8_w;
          8'hc4:   res = STACK_DOWN ? registor_in + d_w : registor_in - d_w;
          8'hec:   res = STACK_DOWN ? registor_in - d_w : registor_in + d_w;
          default: res = registor_in;
        endcase
      end
      8'hc9:   res = (cnt == 2'd2) ? registor_in - S_W : registor_in;
      default: res = registor_in;
    endcase
  end

  // Phase sequencer: IDLE accepts start, RUN registers one result per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= 2'd0;
      n_q            <= 2'd0;
      op_q           <= 32'd0;
      len_q          <= 4'd0;
      ill_pend       <= 1'b0;
      phase          <= 2'd0;
      result_valid   <= 1'b0;
      last           <= 1'b0;
      illegal        <= 1'b0;
      alu_result_bus <= '0;
    end else begin
      result_valid <= 1'b0;
      last         <= 1'b0;
      illegal      <= ill_pend;
      ill_pend     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (start_n == 2'd0) begin
              ill_pend <= 1'b1;
            end else begin
              op_q  <= ope;
              len_q <= num_of_ope;
              n_q   <= start_n;
              cnt   <= 2'd0;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          alu_result_bus <= res;
          result_valid   <= 1'b1;
          phase          <= cnt;
          last           <= is_last;
          cnt            <= cnt + 2'd1;
          if (is_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/x86_alu_seq.md
# x86_alu_seq

Single-clock, parametrised successor to the CPU's multi-phase ALU. It replaces the separate clock_4/clock_6/clock_8 phase clocks with one clock and an internal phase sequencer. It adds a start/busy handshake, per-phase result strobes, illegal-opcode detection, and configurable width and stack direction. It sits between instruction decode, which supplies `ope` and `num_of_ope`, and the register file, which supplies `registor_in` and consumes `alu_result_bus`.

## Interface
- `DATA_W`, default 32: datapath width; must be ≥ 24.
- `STEP`, default 1: stack slot increment for push/pop/call/ret/leave.
- `STACK_DOWN`, default 0: 0 = stack grows upward (push adds `STEP`); 1 = every stack-pointer adjustment sign is inverted.
- `SCALE_SHIFT`, default 2: right-shift applied to byte displacements (the /4 word scaling).

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  — rising-edge clock.
- `reset_n`  in  1  — asynchronous active-low reset.
- `start`  in  1  — request; accepted only while `busy`=0.
- `ope`  in  32  — instruction word; opcode in [31:24], then bytes [23:16], [15:8], [7:0].
- `num_of_ope`  in  4  — instruction length in bytes.
- `registor_in`  in  `DATA_W`  — register operand for the current phase.
- `busy`  out  1  — sequence in progress.
- `phase`  out  2  — index of the result currently on the bus.
- `result_valid`  out  1  — `alu_result_bus` holds a new phase result.
- `last`  out  1  — with `result_valid`, marks the final phase.
- `illegal`  out  1  — one-cycle pulse when `start` carries an unsupported opcode.
- `alu_result_bus`  out  `DATA_W`  — registered result.

## Operation
- States: IDLE, RUN. On `start` in IDLE, latch `ope` and `num_of_ope`, decode the phase count N (1–3), set phase counter = 0, go to RUN. A `start` while `busy` is ignored.
- Notation: R = `registor_in`. S = +`STEP` (−`STEP` if `STACK_DOWN`). d = `ope[15:8]` >> `SCALE_SHIFT`. rel = sign-extend {`ope[7:0]`, `ope[15:8]`, `ope[23:16]`}. Entries are results for phase 0 / phase 1 / phase 2.
- 55, 53 (push): R+S / R.
- 89: R.
- b8: zero-extend {`ope[7:0]`, `ope[15:8]`, `ope[23:16]`}.
- 5d (pop): R / R−S.
- c3 (ret): R−S / R−S.
- e8 (call): R+S / R+`num_of_ope` / R+`num_of_ope`+rel−5.
- 6a: R+S / zero-extend `ope[23:16]`.
- 8b: R−d (R+d if `STACK_DOWN`) / R.
- 83, with modrm in `ope[23:16]`:
  - e8: R−`ope[15:8]`.
  - c4: R−d (R+d if `STACK_DOWN`).
  - ec: R+d (R−d if `STACK_DOWN`).
  - Any other modrm is illegal.
- c9 (leave): R / R / R−S.
- Any other opcode is illegal: `illegal` pulses, no `busy`, no `result_valid`, `alu_result_bus` unchanged.
- Arithmetic is modulo 2^`DATA_W`. Immediates are zero-extended. rel is sign-extended from bit 23.
- `alu_result_bus` holds its last value between valid strobes.

## Timing
- `start` sampled high at edge T. `busy`=1 from T through edge T+N.
- The phase k result is computed from R present during cycle T+k and registered at edge T+k+1. `result_valid`=1 and `phase`=k for the following cycle.
- `last`=1 with phase N−1. `busy` falls at the same edge, so a new `start` is accepted in the `last` cycle. Back-to-back instructions cost N cycles each.
- `illegal` is registered at edge T+1 and lasts one cycle.
- Reset (asynchronous, any time, including mid-RUN): state IDLE; `busy`, `phase`, `result_valid`, `last`, `illegal`, `alu_result_bus` = 0. The aborted sequence emits no further strobes.

## Test plan
- Push: `ope`=32'h55000000, R=0x10 in phase 0 and 0x20 in phase 1 → 0x11 (phase 0), then 0x20 with `last`. `busy` spans 2 cycles.
- Call: `ope`=32'hE8EEFFFF, `num_of_ope`=5, R=0x20 → 0x21, 0x25, 0x0E (rel=−18). `last` on phase 2.
- Immediate: `ope`=32'hB8785634 → single result 0x00345678 with `last` in the first valid cycle. `DATA_W`=64 build gives the same value zero-extended.
- Stack adjust: `ope`=32'h83C40800, R=0x100 → 0xFE. Same with `STACK_DOWN`=1 → 0x102. `ope`=32'h83EC0800 → 0x102 and 0xFE respectively.
- Illegal: `ope`=32'h90000000, then `ope`=32'h83000000 → `illegal` pulse each, no `result_valid`, bus unchanged. A `start` during a c9 sequence is ignored.
- Reset mid-sequence: c9 with R=0x40, `reset_n` low after the phase 0 result → all outputs 0 immediately, no phase 1 or 2 strobes. A new 89 start after reset release gives R with `last`.
